// File: rtl/fitness_eval_pkg.sv
// Shared types and helpers for the circuit fitness evaluator.
package fitness_eval_pkg;

  localparam int unsigned IN_DEF     = 3;
  localparam int unsigned OUT_DEF    = 1;
  localparam int unsigned SETTLE_DEF = 2;
  localparam int unsigned NVEC       = 2 ** IN_DEF;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMP1,
    SAMP2,
    DONE
  } eval_state_t;

  // Callers zero-extend narrower vectors, so only set bits are counted.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/circuit_fitness_eval.sv
// Sweeps all input vectors through the evolved circuit, double-samples each response
// and scores matches against a target truth table, flagging unstable (oscillating) vectors.
module circuit_fitness_eval
  import fitness_eval_pkg::*;
#(
  parameter int unsigned IN         = IN_DEF,
  parameter int unsigned OUT        = OUT_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_DEF,
  localparam int unsigned NV = 2 ** IN,
  localparam int unsigned SW = $clog2(NV * OUT + 1),
  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NV-1:0][OUT-1:0]  target,
  output logic [IN-1:0]           dut_inp,
  input  logic [OUT-1:0]          dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [SW-1:0]           score,
  output logic                    unstable
);

  eval_state_t               r_state, w_state_d;
  logic [CW-1:0]             r_cnt, w_cnt_d;
  logic [IN-1:0]             r_vec, w_vec_d;
  logic [OUT-1:0]            r_s1, w_s1_d;
  logic [NV-1:0][OUT-1:0]    r_target, w_target_d;
  logic [SW-1:0]             r_score, w_score_d;
  logic                      r_unstable, w_unstable_d;
  logic                      r_busy, w_busy_d;
  logic                      r_done, w_done_d;
  logic [OUT-1:0]            w_match;
  logic [SW-1:0]             w_inc;

  assign w_match = ~(r_s1 ^ r_target[r_vec]);
  assign w_inc   = SW'(popcount(32'(w_match)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_vec      <= '0;
      r_s1       <= '0;
      r_target   <= '0;
      r_score    <= '0;
      r_unstable <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_vec      <= w_vec_d;
      r_s1       <= w_s1_d;
      r_target   <= w_target_d;
      r_score    <= w_score_d;
      r_unstable <= w_unstable_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_vec_d      = r_vec;
    w_s1_d       = r_s1;
    w_target_d   = r_target;
    w_score_d    = r_score;
    w_unstable_d = r_unstable;
    w_busy_d     = r_busy;
    w_done_d     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_target_d   = target;
          w_vec_d      = '0;
          w_score_d    = '0;
          w_unstable_d = 1'b0;
          w_busy_d     = 1'b1;
          w_cnt_d      = CW'(SETTLE_CYC - 1);
          w_state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) w_state_d = SAMP1;
        else             w_cnt_d   = r_cnt - CW'(1);
      end
      SAMP1: begin
        w_s1_d    = dut_out;
        w_state_d = SAMP2;
      end
      SAMP2: begin
        // A vector whose two samples disagree contributes nothing to the score.
        if (dut_out == r_s1) w_score_d    = r_score + w_inc;
        else                 w_unstable_d = 1'b1;
        if (r_vec == IN'(NV - 1)) begin
          w_state_d = DONE;
        end else begin
          w_vec_d   = r_vec + IN'(1);
          w_cnt_d   = CW'(SETTLE_CYC - 1);
          w_state_d = SETTLE;
        end
      end
      DONE: begin
        w_busy_d  = 1'b0;
        w_done_d  = 1'b1;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign dut_inp  = r_vec;
  assign busy     = r_busy;
  assign done     = r_done;
  assign score    = r_score;
  assign unstable = r_unstable;

endmodule

// File: tb/tb_circuit_fitness_eval.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop on done.
module tb_circuit_fitness_eval;

  typedef struct {
    int unsigned score;
    bit          unst;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [7:0][0:0] target = '0;
  logic [7:0][1:0] target2 = '0;
  logic [2:0] dut_inp, dut_inp2;
  logic       dut_out;
  logic [1:0] dut_out2;
  logic       busy, done, unstable, busy2, done2, unstable2;
  logic [3:0] score;
  logic [4:0] score2;
  logic       tog = 1'b0;
  int         mode = 0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int ndone1 = 0;
  int ndone2 = 0;
  logic prev_done1 = 1'b0;
  logic prev_done2 = 1'b0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  circuit_fitness_eval #(.IN(3), .OUT(1), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .dut_inp(dut_inp),
    .dut_out(dut_out), .busy(busy), .done(done), .score(score), .unstable(unstable)
  );

  circuit_fitness_eval #(.IN(3), .OUT(2), .SETTLE_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .target(target2), .dut_inp(dut_inp2),
    .dut_out(dut_out2), .busy(busy2), .done(done2), .score(score2), .unstable(unstable2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    tog <= ~tog;
  end

  // Circuit models: identity on bit 0, optionally oscillating on vector 5.
  always_comb dut_out = (mode == 1 && dut_inp == 3'd5) ? tog : dut_inp[0];
  assign dut_out2 = dut_inp2[1:0];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      ndone1++;
      check("done1_width", int'(prev_done1), 0);
      check("busy1_at_done", int'(busy), 0);
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done1_unexpected: got done with no pending start, expected none");
      end else begin
        e1 = q1.pop_front();
        check("score1", int'(score), int'(e1.score));
        check("unstable1", int'(unstable), int'(e1.unst));
        check("latency1", cyc - e1.acc, 33);
      end
    end
    prev_done1 = done;
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      ndone2++;
      check("done2_width", int'(prev_done2), 0);
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done2_unexpected: got done with no pending start, expected none");
      end else begin
        e2 = q2.pop_front();
        check("score2", int'(score2), int'(e2.score));
        check("unstable2", int'(unstable2), int'(e2.unst));
        check("latency2", cyc - e2.acc, 33);
      end
    end
    prev_done2 = done2;
  end

  task automatic start1(input logic [7:0] tgt, input int md, input bit push,
                        input int unsigned es, input bit eu, input bit hold);
    @(negedge clk);
    target = tgt;
    mode   = md;
    start  = 1'b1;
    @(posedge clk);
    #1;
    if (push) q1.push_back('{es, eu, cyc});
    check("busy_after_accept", int'(busy), 1);
    check("score_zero_at_accept", int'(score), 0);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done1(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check("done1_timeout", 0, 1);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_score", int'(score), 0);
    check("rst_unstable", int'(unstable), 0);
    check("rst_dut_inp", int'(dut_inp), 0);
    rst_n = 1'b1;

    // Correct circuit, then fully inverted target, then oscillating vector 5.
    start1(8'b10101010, 0, 1'b1, 8, 1'b0, 1'b0);
    wait_done1(100);
    start1(8'b01010101, 0, 1'b1, 0, 1'b0, 1'b0);
    wait_done1(100);
    repeat (4) @(negedge clk);
    check("single_done_count", ndone1, 2);
    start1(8'b10101010, 1, 1'b1, 7, 1'b1, 1'b0);
    wait_done1(100);

    // Start held high for the whole run: one done only.
    start1(8'b10101010, 0, 1'b1, 8, 1'b0, 1'b1);
    wait_done1(100);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("held_start_done_count", ndone1, 4);
    check("score_holds_after_done", int'(score), 8);
    start1(8'b01010101, 0, 1'b1, 0, 1'b0, 1'b0);
    wait_done1(100);

    // Reset mid-sweep.
    start1(8'b10101010, 0, 1'b0, 0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (dut_inp == 3'd3);
    end
    check("reached_vec3", int'(seen), 1);
    check("score_nonzero_before_reset", int'(score != 0), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_score", int'(score), 0);
    check("midrst_unstable", int'(unstable), 0);
    check("midrst_dut_inp", int'(dut_inp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start1(8'b10101010, 0, 1'b1, 8, 1'b0, 1'b0);
    wait_done1(100);

    // Two-output instance: target 2'b01 everywhere.
    @(negedge clk);
    target2 = 16'h5555;
    start2  = 1'b1;
    @(posedge clk);
    #1;
    q2.push_back('{8, 1'b0, cyc});
    @(negedge clk);
    start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done2;
    end
    if (!seen) check("done2_timeout", 0, 1);

    repeat (4) @(negedge clk);
    check("total_done1", ndone1, 6);
    check("total_done2", ndone2, 1);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
